alarm_controller: RTL

//  Downstream consumer of the real-time clock's sec/min/hours outputs. Holds a

---
 rtl/alarm_pkg.sv | 29 ++
 rtl/alarm_timer.sv | 41 ++++
 rtl/alarm_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alarm_pkg
// Description : Shared types and constants for the alarm controller:
//               FSM state encoding, legal alarm-time ranges, reset alarm
//               value and a small max() helper used to size the timer.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_e;

  localparam int HOUR_MIN        = 1;
  localparam int HOUR_MAX        = 12;
  localparam int MIN_MAX         = 59;
  localparam int ALARM_RST_HOURS = 12;
  localparam int ALARM_RST_MIN   = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_timer.sv
`default_nettype none
// ============================================================================
// Module      : alarm_timer
// Description : Loadable down-counter shared by the RINGING and SNOOZE
//               states. Load has priority over decrement; the count
//               saturates at zero rather than wrapping.
// Ports       : clk        - clock
//               rst        - asynchronous active-low reset (count -> 0)
//               load_i     - load load_val_i into the counter
//               load_val_i - value to load
//               dec_i      - decrement by one (ignored at zero)
//               zero_o     - counter currently equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Alarm consumer of the real-time clock. Stores a 12-h alarm
//               time through a valid/ready handshake, rings when the clock
//               reaches it, and handles snooze, stop and ring timeout.
// Ports       : clk, rst (async active-low)
//               sec/min/hours         - current time from the clock
//               arm_en                - alarm enable level
//               set_valid/set_ready   - alarm-time handshake
//               set_hours/set_min     - requested alarm time
//               set_err               - one-cycle pulse on rejected time
//               snooze/stop           - user controls, sampled each cycle
//               ringing/snoozing      - state indications
//               snooze_cnt            - snoozes used this alarm event
//               alarm_hours/alarm_min - stored alarm readback
//               beep                  - only with ALARM_BEEP_EN: toggles
//                                       while ringing, first cycle = 1
// Config      : `define ALARM_BEEP_EN to add the beep output.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller
  import alarm_pkg::*;
#(
  parameter  int RING_TIMEOUT = 60,
  parameter  int SNOOZE_LEN   = 300,
  parameter  int SNOOZE_MAX   = 3,
  localparam int SNZ_W        = $clog2(SNOOZE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       sec,
  input  logic [5:0]       min,
  input  logic [3:0]       hours,
  input  logic             arm_en,
  input  logic             set_valid,
  output logic             set_ready,
  input  logic [3:0]       set_hours,
  input  logic [5:0]       set_min,
  output logic             set_err,
  input  logic             snooze,
  input  logic             stop,
  output logic             ringing,
  output logic             snoozing,
  output logic [SNZ_W-1:0] snooze_cnt,
  output logic [3:0]       alarm_hours,
  output logic [5:0]       alarm_min
`ifdef ALARM_BEEP_EN
  ,
  output logic             beep
`endif
);

  localparam int c_tmax = max_int(RING_TIMEOUT, SNOOZE_LEN);
  localparam int c_tw   = (c_tmax > 1) ? $clog2(c_tmax) : 1;

  localparam logic [1:0]       c_st_idle    = IDLE;
  localparam logic [1:0]       c_st_armed   = ARMED;
  localparam logic [1:0]       c_st_ringing = RINGING;
  localparam logic [1:0]       c_st_snooze  = SNOOZE;
  localparam logic [c_tw-1:0]  c_ring_load  = c_tw'(RING_TIMEOUT - 1);
  localparam logic [c_tw-1:0]  c_snz_load   = c_tw'(SNOOZE_LEN - 1);
  localparam logic [SNZ_W-1:0] c_snz_max    = SNZ_W'(SNOOZE_MAX);

  logic [1:0]       state_q, state_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic [3:0]       alarm_hours_q;
  logic [5:0]       alarm_min_q;
  logic             set_err_q;
  logic             match_q;

  logic             w_match, w_trigger, w_xfer, w_set_ok;
  logic             w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [c_tw-1:0]  w_tmr_val;

  // Compares against the stored alarm, so a same-cycle set transfer does
  // not affect this cycle's match.
  assign w_match   = (hours == alarm_hours_q) && (min == alarm_min_q) && (sec == 6'd0);
  assign w_trigger = w_match & ~match_q;

  assign set_ready = (state_q == c_st_idle) || (state_q == c_st_armed);
  assign w_xfer    = set_valid & set_ready;
  assign w_set_ok  = (set_hours >= 4'(HOUR_MIN)) && (set_hours <= 4'(HOUR_MAX)) &&
                     (set_min <= 6'(MIN_MAX));

  always_comb begin
    state_d    = state_q;
    snz_cnt_d  = snz_cnt_q;
    w_tmr_load = 1'b0;
    w_tmr_val  = c_ring_load;
    w_tmr_dec  = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (arm_en) state_d = c_st_armed;
      end
      c_st_armed: begin
        if (!arm_en) begin
          state_d = c_st_idle;
        end else if (w_trigger) begin
          state_d    = c_st_ringing;
          snz_cnt_d  = '0;
          w_tmr_load = 1'b1;
        end
      end
      c_st_ringing: begin
        if (!arm_en) begin
          state_d   = c_st_idle;
          snz_cnt_d = '0;
        end else if (stop) begin
          state_d   = c_st_armed;
          snz_cnt_d = '0;
        end else if (snooze && (snz_cnt_q < c_snz_max)) begin
          state_d    = c_st_snooze;
          snz_cnt_d  = snz_cnt_q + 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_snz_load;
        end else if (w_tmr_zero) begin
          state_d   = c_st_armed;
          snz_cnt_d = '0;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: begin // snooze
        if (!arm_en) begin
          state_d   = c_st_idle;
          snz_cnt_d = '0;
        end else if (stop) begin
          state_d   = c_st_armed;
          snz_cnt_d = '0;
        end else if (w_tmr_zero) begin
          state_d    = c_st_ringing;
          w_tmr_load = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= c_st_idle;
      snz_cnt_q     <= '0;
      alarm_hours_q <= 4'(ALARM_RST_HOURS);
      alarm_min_q   <= 6'(ALARM_RST_MIN);
      set_err_q     <= 1'b0;
      match_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      snz_cnt_q <= snz_cnt_d;
      match_q   <= w_match;
      set_err_q <= w_xfer & ~w_set_ok;
      if (w_xfer && w_set_ok) begin
        alarm_hours_q <= set_hours;
        alarm_min_q   <= set_min;
      end
    end
  end

  alarm_timer #(
    .WIDTH (c_tw)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .dec_i      (w_tmr_dec),
    .zero_o     (w_tmr_zero)
  );

  assign ringing     = (state_q == c_st_ringing);
  assign snoozing    = (state_q == c_st_snooze);
  assign snooze_cnt  = snz_cnt_q;
  assign alarm_hours = alarm_hours_q;
  assign alarm_min   = alarm_min_q;
  assign set_err     = set_err_q;

`ifdef ALARM_BEEP_EN
  logic beep_q;

  // Restarts at 1 on every entry into RINGING, including re-ring after snooze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beep_q <= 1'b0;
    end else if (state_d == c_st_ringing) begin
      beep_q <= (state_q == c_st_ringing) ? ~beep_q : 1'b1;
    end else begin
      beep_q <= 1'b0;
    end
  end

  assign beep = beep_q;
`endif

endmodule
`default_nettype wire
